sram_sdi_arb: RTL and testbench

- Two-port arbiter and sequencer for the board's serial SRAM (IS62WVS5128 class, 512 KiB), driven in SDI (dual-I/O) mode.
- Port 0 serves the F8 emulator memory path; port 1 serves the host/debug loader.
- After reset it switches the SRAM into SDI mode, then performs single-byte read/write transactions, granting the ports round-robin.
- Sits between the emulator core and the sram_sck/sram_cs/sram_d pins; the top level builds the tristate from d_o/d_oe.

---
 rtl/f8_sram_pkg.sv | 35 +++
 rtl/sram_sdi_shift.sv | 81 ++++++++
 rtl/sram_sdi_arb.sv | 211 +++++++++++++++++++++
 tb/tb_sram_sdi_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f8_sram_pkg.sv
// Shared constants and types for the serial SRAM arbiter/sequencer.
// Command bytes, FSM state encoding and per-phase sck counts.
package f8_sram_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_EDIO  = 8'h3B;

    localparam int unsigned SCK_W = 5;

    localparam logic [SCK_W-1:0] SCK_CMD   = 5'd4;
    localparam logic [SCK_W-1:0] SCK_ADDR  = 5'd12;
    localparam logic [SCK_W-1:0] SCK_DUMMY = 5'd4;
    localparam logic [SCK_W-1:0] SCK_DATA  = 5'd4;
    localparam logic [SCK_W-1:0] SCK_EDIO  = 5'd8;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StDone
    } state_e;

    // Sub-steps of the power-up EDIO sequence.
    typedef enum logic [1:0] {
        InitStart,
        InitShift,
        InitGap0,
        InitGap1
    } init_step_e;

endpackage

// File: rtl/sram_sdi_shift.sv
// 32-bit shift register with sck phase and pulse counter for the serial SRAM.
// Shifts 1 or 2 bits per sck pulse, MSB first; samples d_i at the end of each sck-high phase.
module sram_sdi_shift
    import f8_sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             wide,
    input  logic             drive,
    input  logic [31:0]      load_data,
    input  logic [SCK_W-1:0] load_sck,
    input  logic [1:0]       d_i,
    output logic [7:0]       rx_byte,
    output logic             sck,
    output logic [1:0]       d_o,
    output logic             done
);

    logic [31:0]      sh_q, sh_d;
    logic [SCK_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             active_q, active_d;
    logic             wide_q, wide_d;
    logic             drive_q, drive_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            active_q <= 1'b0;
            wide_q   <= 1'b0;
            drive_q  <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            active_q <= active_d;
            wide_q   <= wide_d;
            drive_q  <= drive_d;
        end
    end

    // Last sck-high phase of the segment; a load in this cycle continues sck seamlessly.
    assign done = active_q && phase_q && (cnt_q == SCK_W'(1));

    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        active_d = active_q;
        wide_d   = wide_q;
        drive_d  = drive_q;
        if (active_q) begin
            phase_d = ~phase_q;
            if (phase_q) begin
                sh_d  = wide_q ? {sh_q[29:0], d_i} : {sh_q[30:0], d_i[1]};
                cnt_d = cnt_q - SCK_W'(1);
                if (cnt_q == SCK_W'(1)) begin
                    active_d = 1'b0;
                    drive_d  = 1'b0;
                end
            end
        end
        if (load) begin
            sh_d     = load_data;
            cnt_d    = load_sck;
            phase_d  = 1'b0;
            active_d = 1'b1;
            wide_d   = wide;
            drive_d  = drive;
        end
    end

    assign sck     = phase_q;
    assign d_o     = drive_q ? (wide_q ? sh_q[31:30] : {1'b0, sh_q[31]}) : 2'b00;
    // Byte completed by the sample taken at the current edge.
    assign rx_byte = {sh_q[5:0], d_i};

endmodule

// File: rtl/sram_sdi_arb.sv
// Two-port round-robin arbiter and SDI sequencer for a serial SRAM.
// Switches the part to SDI mode after reset, then runs single-byte read/write transactions.
module sram_sdi_arb
    import f8_sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 19,
    parameter bit          INIT_SDI = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic [1:0]        ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              init_done,
    output logic              sram_cs_n,
    output logic              sram_sck,
    output logic [1:0]        d_o,
    output logic [1:0]        d_oe,
    input  logic [1:0]        d_i
);

    state_e            state_q, state_d;
    init_step_e        init_step_q, init_step_d;
    logic              init_done_q, init_done_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              cs_n_q, cs_n_d;
    logic [1:0]        d_oe_q, d_oe_d;

    logic              sh_load, sh_wide, sh_drive, sh_done;
    logic [31:0]       sh_data;
    logic [SCK_W-1:0]  sh_sck;
    logic [7:0]        rx_byte;
    logic              gnt_sel;

    sram_sdi_shift u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .wide      (sh_wide),
        .drive     (sh_drive),
        .load_data (sh_data),
        .load_sck  (sh_sck),
        .d_i       (d_i),
        .rx_byte   (rx_byte),
        .sck       (sram_sck),
        .d_o       (d_o),
        .done      (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StInit;
            init_step_q <= InitStart;
            init_done_q <= 1'b0;
            rr_q        <= 1'b0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cs_n_q      <= 1'b1;
            d_oe_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            init_step_q <= init_step_d;
            init_done_q <= init_done_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cs_n_q      <= cs_n_d;
            d_oe_q      <= d_oe_d;
        end
    end

    // Contended requests go to the rr pointer; a lone request wins outright.
    assign gnt_sel = (req == 2'b11) ? rr_q : req[1];

    always_comb begin
        state_d     = state_q;
        init_step_d = init_step_q;
        init_done_d = init_done_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cs_n_d      = cs_n_q;
        d_oe_d      = d_oe_q;
        sh_load     = 1'b0;
        sh_wide     = 1'b1;
        sh_drive    = 1'b1;
        sh_data     = '0;
        sh_sck      = '0;

        unique case (state_q)
            StInit: begin
                unique case (init_step_q)
                    InitStart: begin
                        if (INIT_SDI) begin
                            sh_load     = 1'b1;
                            sh_wide     = 1'b0;
                            sh_data     = {CMD_EDIO, 24'h0};
                            sh_sck      = SCK_EDIO;
                            cs_n_d      = 1'b0;
                            d_oe_d      = 2'b01;
                            init_step_d = InitShift;
                        end else begin
                            state_d     = StIdle;
                            init_done_d = 1'b1;
                        end
                    end
                    InitShift: begin
                        if (sh_done) begin
                            cs_n_d      = 1'b1;
                            d_oe_d      = 2'b00;
                            init_step_d = InitGap0;
                        end
                    end
                    InitGap0: init_step_d = InitGap1;
                    InitGap1: begin
                        state_d     = StIdle;
                        init_done_d = 1'b1;
                    end
                    default: init_step_d = InitStart;
                endcase
            end
            StIdle: begin
                if ((|req) && init_done_q) begin
                    gnt_d    = gnt_sel;
                    rr_d     = ~gnt_sel;
                    we_d     = gnt_sel ? we[1] : we[0];
                    addr_d   = gnt_sel ? addr1 : addr0;
                    wdata_d  = gnt_sel ? wdata1 : wdata0;
                    sh_load  = 1'b1;
                    sh_data  = {(we_d ? CMD_WRITE : CMD_READ), 24'h0};
                    sh_sck   = SCK_CMD;
                    cs_n_d   = 1'b0;
                    d_oe_d   = 2'b11;
                    state_d  = StCmd;
                end
            end
            StCmd: begin
                if (sh_done) begin
                    sh_load = 1'b1;
                    sh_data = {24'(addr_q), 8'h0};
                    sh_sck  = SCK_ADDR;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (sh_done) begin
                    sh_load = 1'b1;
                    if (we_q) begin
                        sh_data = {wdata_q, 24'h0};
                        sh_sck  = SCK_DATA;
                        state_d = StData;
                    end else begin
                        // Release the bus for the turnaround before the SRAM drives data.
                        sh_drive = 1'b0;
                        sh_sck   = SCK_DUMMY;
                        d_oe_d   = 2'b00;
                        state_d  = StDummy;
                    end
                end
            end
            StDummy: begin
                if (sh_done) begin
                    sh_load  = 1'b1;
                    sh_drive = 1'b0;
                    sh_sck   = SCK_DATA;
                    state_d  = StData;
                end
            end
            StData: begin
                if (sh_done) begin
                    if (!we_q) begin
                        rdata_d = rx_byte;
                    end
                    cs_n_d  = 1'b1;
                    d_oe_d  = 2'b00;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    assign ack       = (state_q == StDone) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rdata     = rdata_q;
    assign busy      = (state_q != StIdle) || (|req);
    assign init_done = init_done_q;
    assign sram_cs_n = cs_n_q;
    assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_sram_sdi_arb.sv
// Scoreboard bench for sram_sdi_arb: an SRAM bus model checks each cs_n frame and a
// separate ack monitor checks completions, both against expectations queued by the stimulus.
module tb_sram_sdi_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [18:0] addr0 = '0;
    logic [18:0] addr1 = '0;
    logic [7:0]  wdata0 = '0;
    logic [7:0]  wdata1 = '0;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic        init_done;
    logic        sram_cs_n;
    logic        sram_sck;
    logic [1:0]  d_o;
    logic [1:0]  d_oe;
    logic [1:0]  d_i;

    always #5 clk = ~clk;

    sram_sdi_arb #(
        .ADDR_W   (19),
        .INIT_SDI (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .init_done (init_done),
        .sram_cs_n (sram_cs_n),
        .sram_sck  (sram_sck),
        .d_o       (d_o),
        .d_oe      (d_oe),
        .d_i       (d_i)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rbyte;
    } txn_t;

    txn_t bus_q[$];
    txn_t ack_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc++;

    // SRAM bus model: captures one entry per sck pulse, drives read data in phase A.
    logic [1:0] f_do [32];
    logic [1:0] f_oe [32];
    int         f_n = 0;
    bit         in_frame = 0;
    bit         seen_frame = 0;
    int         hi_cnt = 0;
    int         cs_fall_cyc = 0;
    int         edio_frames = 0;
    int         drive_idx = 0;
    logic [7:0] drive_byte = 8'h00;

    assign d_i = (drive_idx >= 20 && drive_idx < 24) ?
                 2'(drive_byte >> (6 - 2 * (drive_idx - 20))) : 2'b00;

    task automatic end_frame();
        txn_t        t;
        logic [7:0]  b;
        logic [31:0] got_ca;
        logic [7:0]  got_wd;
        bit          oe_ok;
        logic [1:0]  exp_oe;
        b      = 8'h00;
        got_ca = '0;
        got_wd = '0;
        oe_ok  = 1'b1;
        if (!init_done) begin
            edio_frames++;
            check("edio_len", 64'(f_n), 64'd8);
            for (int i = 0; i < 8; i++) begin
                b = {b[6:0], f_do[i][0]};
                if (f_oe[i] !== 2'b01 || f_do[i][1] !== 1'b0) oe_ok = 1'b0;
            end
            check("edio_byte", 64'(b), 64'h3B);
            check("edio_oe", 64'(oe_ok), 64'd1);
        end else if (bus_q.size() == 0) begin
            check("bus_unexpected_frame", 64'(f_n), 64'd0);
        end else begin
            t = bus_q.pop_front();
            check("frame_len", 64'(f_n), t.we ? 64'd20 : 64'd24);
            for (int i = 0; i < 16; i++) got_ca = {got_ca[29:0], f_do[i]};
            check("frame_cmd_addr", 64'(got_ca), 64'({(t.we ? 8'h02 : 8'h03), t.addr}));
            if (t.we) begin
                for (int i = 16; i < 20; i++) got_wd = {got_wd[5:0], f_do[i]};
                check("frame_wdata", 64'(got_wd), 64'(t.wdata));
            end
            for (int i = 0; i < f_n && i < 32; i++) begin
                exp_oe = (i < 16 || t.we) ? 2'b11 : 2'b00;
                if (f_oe[i] !== exp_oe) oe_ok = 1'b0;
            end
            check("frame_oe", 64'(oe_ok), 64'd1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame   = 0;
            seen_frame = 0;
            f_n        = 0;
            hi_cnt     = 0;
            drive_idx  = 0;
        end else if (!sram_cs_n) begin
            if (!in_frame) begin
                in_frame    = 1;
                f_n         = 0;
                cs_fall_cyc = cyc;
                if (seen_frame) check("cs_gap_ge2", 64'(hi_cnt >= 2), 64'd1);
                hi_cnt = 0;
                if (bus_q.size() > 0) drive_byte = bus_q[0].rbyte;
            end
            if (sram_sck) begin
                if (f_n < 32) begin
                    f_do[f_n] = d_o;
                    f_oe[f_n] = d_oe;
                end
                f_n++;
            end else begin
                drive_idx = f_n;
            end
        end else begin
            hi_cnt++;
            if (in_frame) begin
                in_frame   = 0;
                seen_frame = 1;
                drive_idx  = 0;
                end_frame();
            end
        end
    end

    // Ack monitor.
    txn_t ack_t;
    always @(negedge clk) begin
        if (rst_n && ack != 2'b00) begin
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                ack_t = ack_q.pop_front();
                check("ack_port", 64'(ack), ack_t.port ? 64'd2 : 64'd1);
                check("ack_latency", 64'(cyc - cs_fall_cyc), ack_t.we ? 64'd40 : 64'd48);
                check("ack_busy", 64'(busy), 64'd1);
                if (!ack_t.we) check("ack_rdata", 64'(rdata), 64'(ack_t.rbyte));
            end
        end
    end

    function automatic txn_t mk(input logic p, input logic w, input logic [18:0] a,
                                input logic [7:0] wd, input logic [7:0] rb);
        txn_t t;
        t.port  = p;
        t.we    = w;
        t.addr  = 24'(a);
        t.wdata = wd;
        t.rbyte = rb;
        return t;
    endfunction

    task automatic wait_ack(input int p, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic p, input logic w, input logic [18:0] a,
                          input logic [7:0] wd, input logic [7:0] rb, input bit perturb);
        txn_t t;
        bit   ok;
        t = mk(p, w, a, wd, rb);
        bus_q.push_back(t);
        ack_q.push_back(t);
        if (p) begin
            we[1] = w; addr1 = a; wdata1 = wd;
        end else begin
            we[0] = w; addr0 = a; wdata0 = wd;
        end
        req[p] = 1'b1;
        if (perturb) begin
            repeat (10) @(negedge clk);
            if (p) begin
                addr1 = ~a; wdata1 = ~wd; we[1] = ~w;
            end else begin
                addr0 = ~a; wdata0 = ~wd; we[0] = ~w;
            end
        end
        wait_ack(p, 200, ok);
        req[p] = 1'b0;
        check("ack_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   ok;
        int   n;
        txn_t t;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({sram_cs_n, sram_sck, d_o, d_oe, ack, rdata, busy, init_done}),
              64'({1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0}));

        // INIT: EDIO frame, then init_done after cs_n returns high.
        rst_n = 1'b1;
        @(negedge clk);
        check("init_cs_low_oe01", 64'({sram_cs_n, d_oe}), 64'(3'b0_01));
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sram_cs_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("init_cs_release", 64'(ok), 64'd1);
        check("init_done_low_at_cs_rise", 64'(init_done), 64'd0);
        repeat (2) @(negedge clk);
        check("init_done_high", 64'(init_done), 64'd1);

        // Port 0 write, port 1 read.
        do_txn(1'b0, 1'b1, 19'h01234, 8'hA5, 8'h00, 1'b0);
        @(negedge clk);
        check("idle_not_busy", 64'(busy), 64'd0);
        do_txn(1'b1, 1'b0, 19'h7FFFF, 8'h00, 8'h5A, 1'b0);
        repeat (5) @(negedge clk);
        check("rdata_held", 64'(rdata), 64'h5A);

        // Requester inputs change after grant; write keeps latched values.
        do_txn(1'b0, 1'b1, 19'h00C3C, 8'h96, 8'h00, 1'b1);
        @(negedge clk);
        check("rdata_held_after_write", 64'(rdata), 64'h5A);

        // Reset during ADDR of a port 0 read; INIT reruns, read then completes once.
        t = mk(1'b0, 1'b0, 19'h00ABC, 8'h00, 8'hC3);
        bus_q.push_back(t);
        ack_q.push_back(t);
        we[0] = 1'b0; addr0 = 19'h00ABC;
        req[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sram_cs_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_cs_low", 64'(ok), 64'd1);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_reset_outputs",
                 64'({sram_cs_n, sram_sck, d_o, d_oe, ack, rdata, busy, init_done}),
                 64'({1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 1'b0}));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, 300, ok);
        req[0] = 1'b0;
        check("abort_ack_seen", 64'(ok), 64'd1);
        repeat (60) @(negedge clk);
        check("edio_rerun", 64'(edio_frames), 64'd2);

        // Both ports requesting continuously from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = mk(1'b0, 1'b1, 19'h00010, 8'h11, 8'h00);
            bus_q.push_back(t);
            ack_q.push_back(t);
            t = mk(1'b1, 1'b0, 19'h00020, 8'h00, 8'h22);
            bus_q.push_back(t);
            ack_q.push_back(t);
        end
        we = 2'b01; addr0 = 19'h00010; wdata0 = 8'h11; addr1 = 19'h00020;
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack != 2'b00) n++;
            if (n == 4) break;
        end
        req = 2'b00;
        check("rr_ack_count", 64'(n), 64'd4);

        repeat (10) @(negedge clk);
        check("queues_drained", 64'(bus_q.size() + ack_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
